// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers; MTHI/MTLO write in 1 edge, mul/div take WIDTH+1 cycles.
// busy is high from the issuing edge until the edge that writes hi/lo; start is ignored while busy.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_lat;
    logic               is_div;
    logic               div_zero;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} for multiplies and {remainder, dividend/quotient} for divides
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        acc_step  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH])
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        prod_s = neg_res ? -acc : acc;
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_lat;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_lat    <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (!op[2]) begin
                            state    <= S_RUN;
                            cnt      <= '0;
                            a_lat    <= a;
                            is_div   <= op[1];
                            div_zero <= (b == '0);
                            neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= signed_op & a[WIDTH-1];
                            opnd     <= op[1] ? b_mag : a_mag;
                            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        end else if (!op[1]) begin
                            if (!op[0])
                                hi_q <= a;
                            else
                                lo_q <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_step;
                        if (cnt == CW'(WIDTH - 1))
                            state <= S_FINISH;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
